// File: rtl/miriscv_data_arbiter.sv
// miriscv_data_arbiter: shares the core data-memory port between two masters
// (M0 = LSU, M1 = debug/DMA). One transaction outstanding; request fields are
// registered on grant and the response is routed back to the granted master.
// Optional feature: define MIRISCV_DATA_ARB_TIMEOUT_EN to abandon a transaction
// after TIMEOUT_CYCLES busy cycles without data_rvalid_i.
module miriscv_data_arbiter #(
  parameter int unsigned XLEN           = 32,
  parameter bit          FIXED_PRIO     = 1'b0,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic              clk_i,
  input  logic              arstn_i,

  input  logic              m0_req_i,
  input  logic              m0_we_i,
  input  logic [XLEN/8-1:0] m0_be_i,
  input  logic [XLEN-1:0]   m0_addr_i,
  input  logic [XLEN-1:0]   m0_wdata_i,
  output logic              m0_rvalid_o,
  output logic [XLEN-1:0]   m0_rdata_o,

  input  logic              m1_req_i,
  input  logic              m1_we_i,
  input  logic [XLEN/8-1:0] m1_be_i,
  input  logic [XLEN-1:0]   m1_addr_i,
  input  logic [XLEN-1:0]   m1_wdata_i,
  output logic              m1_rvalid_o,
  output logic [XLEN-1:0]   m1_rdata_o,

  output logic              data_req_o,
  output logic              data_we_o,
  output logic [XLEN/8-1:0] data_be_o,
  output logic [XLEN-1:0]   data_addr_o,
  output logic [XLEN-1:0]   data_wdata_o,
  input  logic              data_rvalid_i,
  input  logic [XLEN-1:0]   data_rdata_i,

  output logic              arb_busy_o,
  output logic              arb_timeout_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY0 = 2'd1,
    BUSY1 = 2'd2
  } state_t;

  state_t state, state_next;
  logic   last_grant, last_grant_next;  // 0: M0 granted last, 1: M1 granted last
  logic   abort, abort_next;
  logic   grant0, grant1;
  logic   timeout_hit;

`ifdef MIRISCV_DATA_ARB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES);
  logic [CW-1:0] tmo_cnt;

  // Busy-cycle counter; restarts on every grant and on completion
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      tmo_cnt <= '0;
    end else if (state == IDLE || data_rvalid_i || timeout_hit) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + CW'(1);
    end
  end

  // A real response in the final cycle wins over the abandon
  assign timeout_hit = (state != IDLE) && !data_rvalid_i &&
                       (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // State, arbitration history and kill flag
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      abort      <= 1'b0;
    end else begin
      state      <= state_next;
      last_grant <= last_grant_next;
      abort      <= abort_next;
    end
  end

  // Arbitration, next state and response routing
  always_comb begin
    state_next      = state;
    last_grant_next = last_grant;
    abort_next      = abort;
    grant0          = 1'b0;
    grant1          = 1'b0;
    m0_rvalid_o     = 1'b0;
    m1_rvalid_o     = 1'b0;
    m0_rdata_o      = '0;
    m1_rdata_o      = '0;
    unique case (state)
      IDLE: begin
        if (m0_req_i && m1_req_i) begin
          if (FIXED_PRIO || last_grant) grant0 = 1'b1;
          else                          grant1 = 1'b1;
        end else if (m0_req_i) begin
          grant0 = 1'b1;
        end else if (m1_req_i) begin
          grant1 = 1'b1;
        end
        if (grant0) begin
          state_next      = BUSY0;
          last_grant_next = 1'b0;
          abort_next      = 1'b0;
        end else if (grant1) begin
          state_next      = BUSY1;
          last_grant_next = 1'b1;
          abort_next      = 1'b0;
        end
      end
      BUSY0: begin
        if (data_rvalid_i || timeout_hit) begin
          m0_rvalid_o = !abort;
          m0_rdata_o  = (data_rvalid_i && !abort) ? data_rdata_i : '0;
          state_next  = IDLE;
          abort_next  = 1'b0;
        end else if (!m0_req_i) begin
          abort_next  = 1'b1;
        end
      end
      BUSY1: begin
        if (data_rvalid_i || timeout_hit) begin
          m1_rvalid_o = !abort;
          m1_rdata_o  = (data_rvalid_i && !abort) ? data_rdata_i : '0;
          state_next  = IDLE;
          abort_next  = 1'b0;
        end else if (!m1_req_i) begin
          abort_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Memory-side request registers; fields only load on a grant
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      data_req_o   <= 1'b0;
      data_we_o    <= 1'b0;
      data_be_o    <= '0;
      data_addr_o  <= '0;
      data_wdata_o <= '0;
    end else if (grant0) begin
      data_req_o   <= 1'b1;
      data_we_o    <= m0_we_i;
      data_be_o    <= m0_be_i;
      data_addr_o  <= m0_addr_i;
      data_wdata_o <= m0_wdata_i;
    end else if (grant1) begin
      data_req_o   <= 1'b1;
      data_we_o    <= m1_we_i;
      data_be_o    <= m1_be_i;
      data_addr_o  <= m1_addr_i;
      data_wdata_o <= m1_wdata_i;
    end else if (state != IDLE && (data_rvalid_i || timeout_hit)) begin
      data_req_o   <= 1'b0;
    end
  end

  assign arb_busy_o    = (state != IDLE);
  assign arb_timeout_o = timeout_hit;

endmodule

// File: tb/tb_miriscv_data_arbiter.sv
// Testbench for miriscv_data_arbiter: directed scenarios plus randomized
// traffic checked against a transaction-level reference model.
module tb_miriscv_data_arbiter;

  localparam int TMO = 4;
`ifdef MIRISCV_DATA_ARB_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic arstn;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [3:0]  m0_be, m1_be;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        data_rvalid;
  logic [31:0] data_rdata;

  logic        m0_rvalid, m1_rvalid, data_req, data_we, busy, tmo;
  logic [31:0] m0_rdata, m1_rdata, data_addr, data_wdata;
  logic [3:0]  data_be;

  logic        fp_m0_rvalid, fp_m1_rvalid, fp_data_req, fp_data_we, fp_busy, fp_tmo;
  logic [31:0] fp_m0_rdata, fp_m1_rdata, fp_data_addr, fp_data_wdata;
  logic [3:0]  fp_data_be;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  miriscv_data_arbiter #(.XLEN(32), .FIXED_PRIO(1'b0), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_i(clk), .arstn_i(arstn),
    .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_be_i(m0_be), .m0_addr_i(m0_addr),
    .m0_wdata_i(m0_wdata), .m0_rvalid_o(m0_rvalid), .m0_rdata_o(m0_rdata),
    .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_be_i(m1_be), .m1_addr_i(m1_addr),
    .m1_wdata_i(m1_wdata), .m1_rvalid_o(m1_rvalid), .m1_rdata_o(m1_rdata),
    .data_req_o(data_req), .data_we_o(data_we), .data_be_o(data_be),
    .data_addr_o(data_addr), .data_wdata_o(data_wdata),
    .data_rvalid_i(data_rvalid), .data_rdata_i(data_rdata),
    .arb_busy_o(busy), .arb_timeout_o(tmo)
  );

  miriscv_data_arbiter #(.XLEN(32), .FIXED_PRIO(1'b1), .TIMEOUT_CYCLES(TMO)) dut_fp (
    .clk_i(clk), .arstn_i(arstn),
    .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_be_i(m0_be), .m0_addr_i(m0_addr),
    .m0_wdata_i(m0_wdata), .m0_rvalid_o(fp_m0_rvalid), .m0_rdata_o(fp_m0_rdata),
    .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_be_i(m1_be), .m1_addr_i(m1_addr),
    .m1_wdata_i(m1_wdata), .m1_rvalid_o(fp_m1_rvalid), .m1_rdata_o(fp_m1_rdata),
    .data_req_o(fp_data_req), .data_we_o(fp_data_we), .data_be_o(fp_data_be),
    .data_addr_o(fp_data_addr), .data_wdata_o(fp_data_wdata),
    .data_rvalid_i(data_rvalid), .data_rdata_i(data_rdata),
    .arb_busy_o(fp_busy), .arb_timeout_o(fp_tmo)
  );

  task automatic clear_inputs();
    m0_req = 1'b0; m0_we = 1'b0; m0_be = '0; m0_addr = '0; m0_wdata = '0;
    m1_req = 1'b0; m1_we = 1'b0; m1_be = '0; m1_addr = '0; m1_wdata = '0;
    data_rvalid = 1'b0; data_rdata = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_inputs();
    arstn = 1'b0;
    @(negedge clk);
    arstn = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    m0_req = 1'b1; m1_req = 1'b1; data_rvalid = 1'b1; data_rdata = 32'hFFFF_FFFF;
    #1;
    checks++; if (data_req !== 1'b0) begin errors++; $display("FAIL reset_data_req got %b exp 0", data_req); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL reset_timeout got %b exp 0", tmo); end
    checks++; if ({m0_rvalid, m1_rvalid} !== 2'b00) begin errors++; $display("FAIL reset_rvalid got %b exp 00", {m0_rvalid, m1_rvalid}); end
    checks++; if ({m0_rdata, m1_rdata} !== 64'h0) begin errors++; $display("FAIL reset_rdata got %h exp 0", {m0_rdata, m1_rdata}); end
    checks++; if ({data_we, data_be, data_addr, data_wdata} !== 69'h0) begin errors++; $display("FAIL reset_fields got %h exp 0", {data_we, data_be, data_addr, data_wdata}); end
    @(negedge clk);
    clear_inputs();
    arstn = 1'b1;
  endtask

  task automatic test_m0_load();
    @(negedge clk);
    m0_req = 1'b1; m0_we = 1'b0; m0_be = 4'hF; m0_addr = 32'h100; m0_wdata = '0;
    #1;
    checks++; if (data_req !== 1'b0) begin errors++; $display("FAIL load_req_T got %b exp 0", data_req); end
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 4) begin data_rvalid = 1'b1; data_rdata = 32'hDEAD_BEEF; end
      #1;
      checks++; if (data_req !== 1'b1) begin errors++; $display("FAIL load_req_T+%0d got %b exp 1", k, data_req); end
      checks++; if (data_addr !== 32'h100) begin errors++; $display("FAIL load_addr got %h exp 100", data_addr); end
      checks++; if (m0_rvalid !== (k == 4)) begin errors++; $display("FAIL load_m0_rvalid_T+%0d got %b exp %b", k, m0_rvalid, (k == 4)); end
      checks++; if (m1_rvalid !== 1'b0 || m1_rdata !== 32'h0) begin errors++; $display("FAIL load_m1_silent got %b/%h exp 0/0", m1_rvalid, m1_rdata); end
    end
    checks++; if (m0_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL load_m0_rdata got %h exp deadbeef", m0_rdata); end
    @(negedge clk);
    m0_req = 1'b0; data_rvalid = 1'b0; data_rdata = '0;
    #1;
    checks++; if (data_req !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL load_end got req %b busy %b exp 0 0", data_req, busy); end
    checks++; if (m0_rvalid !== 1'b0) begin errors++; $display("FAIL load_end_rvalid got %b exp 0", m0_rvalid); end
  endtask

  task automatic test_tie();
    logic [31:0] exp_addr [3];
    exp_addr[0] = 32'h10; exp_addr[1] = 32'h20; exp_addr[2] = 32'h10;
    do_reset();
    @(negedge clk);
    m0_req = 1'b1; m0_addr = 32'h10; m0_be = 4'hF;
    m1_req = 1'b1; m1_addr = 32'h20; m1_be = 4'hF;
    for (int g = 0; g < 3; g++) begin
      @(negedge clk);
      data_rvalid = 1'b1; data_rdata = 32'hA0 + 32'(g);
      #1;
      checks++; if (data_addr !== exp_addr[g]) begin errors++; $display("FAIL rr_grant%0d_addr got %h exp %h", g, data_addr, exp_addr[g]); end
      checks++; if (m0_rvalid !== (g != 1) || m1_rvalid !== (g == 1)) begin errors++; $display("FAIL rr_grant%0d_rvalid got %b%b exp %b%b", g, m0_rvalid, m1_rvalid, (g != 1), (g == 1)); end
      checks++; if (fp_data_addr !== 32'h10 || fp_m0_rvalid !== 1'b1) begin errors++; $display("FAIL fp_grant%0d got addr %h rvalid %b exp 10 1", g, fp_data_addr, fp_m0_rvalid); end
      @(negedge clk);
      data_rvalid = 1'b0;
      #1;
      checks++; if (data_req !== 1'b0 || fp_data_req !== 1'b0) begin errors++; $display("FAIL tie_bubble%0d got %b%b exp 00", g, data_req, fp_data_req); end
    end
    m0_req = 1'b0; m1_req = 1'b0;
  endtask

  task automatic test_store_stable();
    @(negedge clk);
    m1_req = 1'b1; m1_we = 1'b1; m1_be = 4'b0011; m1_addr = 32'h200; m1_wdata = 32'h1234;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      if (k == 1) begin m0_req = 1'b1; m0_we = 1'b0; m0_be = 4'hF; m0_addr = 32'h444; end
      if (k == 2) begin m1_addr = 32'h300; m1_be = 4'b1100; m1_wdata = 32'hFFFF; m1_we = 1'b0; end
      if (k == 3) begin data_rvalid = 1'b1; data_rdata = 32'h55AA; end
      #1;
      checks++; if ({data_req, data_we, data_be, data_addr, data_wdata} !== {1'b1, 1'b1, 4'b0011, 32'h200, 32'h1234})
        begin errors++; $display("FAIL store_stable_k%0d got %b %b %b %h %h exp 1 1 0011 200 1234", k, data_req, data_we, data_be, data_addr, data_wdata); end
      checks++; if (m0_rvalid !== 1'b0 || m0_rdata !== 32'h0) begin errors++; $display("FAIL store_m0_stall got %b/%h exp 0/0", m0_rvalid, m0_rdata); end
    end
    checks++; if (m1_rvalid !== 1'b1 || m1_rdata !== 32'h55AA) begin errors++; $display("FAIL store_m1_resp got %b/%h exp 1/55aa", m1_rvalid, m1_rdata); end
    @(negedge clk);
    m1_req = 1'b0; data_rvalid = 1'b0;
    #1;
    checks++; if (data_req !== 1'b0) begin errors++; $display("FAIL store_bubble got %b exp 0", data_req); end
    @(negedge clk);
    data_rvalid = 1'b1; data_rdata = 32'h77;
    #1;
    checks++; if (data_req !== 1'b1 || data_addr !== 32'h444) begin errors++; $display("FAIL stalled_m0_grant got %b/%h exp 1/444", data_req, data_addr); end
    checks++; if (m0_rvalid !== 1'b1 || m0_rdata !== 32'h77) begin errors++; $display("FAIL stalled_m0_resp got %b/%h exp 1/77", m0_rvalid, m0_rdata); end
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_kill();
    @(negedge clk);
    m0_req = 1'b1; m0_be = 4'hF; m0_addr = 32'h400;
    @(negedge clk);
    m0_req = 1'b0;
    #1;
    checks++; if (data_req !== 1'b1) begin errors++; $display("FAIL kill_req1 got %b exp 1", data_req); end
    @(negedge clk);
    m0_req = 1'b1; m0_addr = 32'h500;
    #1;
    checks++; if (data_req !== 1'b1 || data_addr !== 32'h400) begin errors++; $display("FAIL kill_hold got %b/%h exp 1/400", data_req, data_addr); end
    @(negedge clk);
    data_rvalid = 1'b1; data_rdata = 32'hBAD;
    #1;
    checks++; if (m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0) begin errors++; $display("FAIL kill_swallow got %b%b exp 00", m0_rvalid, m1_rvalid); end
    checks++; if (data_req !== 1'b1 || busy !== 1'b1 || data_addr !== 32'h400) begin errors++; $display("FAIL kill_rvalid_cycle got %b %b %h exp 1 1 400", data_req, busy, data_addr); end
    @(negedge clk);
    data_rvalid = 1'b0;
    #1;
    checks++; if (data_req !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL kill_idle got %b %b exp 0 0", data_req, busy); end
    @(negedge clk);
    data_rvalid = 1'b1; data_rdata = 32'h600D;
    #1;
    checks++; if (data_addr !== 32'h500 || m0_rvalid !== 1'b1 || m0_rdata !== 32'h600D) begin errors++; $display("FAIL kill_rereq got %h %b %h exp 500 1 600d", data_addr, m0_rvalid, m0_rdata); end
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    m0_req = 1'b1; m0_be = 4'hF; m0_addr = 32'h600;
    @(negedge clk);
    #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL arst_pre_busy got %b exp 1", busy); end
    #1 arstn = 1'b0;
    #1;
    checks++; if (data_req !== 1'b0 || busy !== 1'b0 || data_addr !== 32'h0) begin errors++; $display("FAIL arst_immediate got %b %b %h exp 0 0 0", data_req, busy, data_addr); end
    @(negedge clk);
    arstn = 1'b1; m0_req = 1'b0; data_rvalid = 1'b1; data_rdata = 32'h1111;
    #1;
    checks++; if (m0_rvalid !== 1'b0 || busy !== 1'b0 || data_req !== 1'b0) begin errors++; $display("FAIL arst_late_rvalid got %b %b %b exp 0 0 0", m0_rvalid, busy, data_req); end
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_timeout();
    @(negedge clk);
    m0_req = 1'b1; m0_be = 4'hF; m0_addr = 32'h700; data_rdata = 32'hFFFF_FFFF;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      #1;
`ifdef MIRISCV_DATA_ARB_TIMEOUT_EN
      if (k <= 4) begin
        checks++; if (busy !== 1'b1 || tmo !== (k == 4)) begin errors++; $display("FAIL tmo_k%0d got busy %b tmo %b exp 1 %b", k, busy, tmo, (k == 4)); end
        checks++; if (m0_rvalid !== (k == 4)) begin errors++; $display("FAIL tmo_rvalid_k%0d got %b exp %b", k, m0_rvalid, (k == 4)); end
        if (k == 4) begin
          checks++; if (m0_rdata !== 32'h0) begin errors++; $display("FAIL tmo_rdata got %h exp 0", m0_rdata); end
          m0_req = 1'b0;
        end
      end else begin
        checks++; if (busy !== 1'b0 || tmo !== 1'b0 || data_req !== 1'b0) begin errors++; $display("FAIL tmo_after_k%0d got %b %b %b exp 0 0 0", k, busy, tmo, data_req); end
      end
`else
      checks++; if (busy !== 1'b1 || data_req !== 1'b1 || tmo !== 1'b0 || m0_rvalid !== 1'b0) begin errors++; $display("FAIL notmo_k%0d got %b %b %b %b exp 1 1 0 0", k, busy, data_req, tmo, m0_rvalid); end
`endif
    end
`ifndef MIRISCV_DATA_ARB_TIMEOUT_EN
    @(negedge clk);
    data_rvalid = 1'b1; data_rdata = 32'h42;
    #1;
    checks++; if (m0_rvalid !== 1'b1 || m0_rdata !== 32'h42) begin errors++; $display("FAIL notmo_finish got %b/%h exp 1/42", m0_rvalid, m0_rdata); end
`endif
    @(negedge clk);
    clear_inputs();
  endtask

  // Transaction-level model: who owns the port, whether the owner walked away,
  // how long it has waited, and the request that was captured at grant.
  task automatic test_random();
    int owner, last, age, pick;
    bit killed, tmo_now, done, rv0e, rv1e;
    logic        q_we;
    logic [3:0]  q_be;
    logic [31:0] q_addr, q_wdata, rd_e;
    do_reset();
    owner = -1; last = 1; age = 0; killed = 1'b0;
    q_we = 1'b0; q_be = '0; q_addr = '0; q_wdata = '0;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      m0_req = ($urandom_range(0, 9) < 6); m0_we = 1'($urandom); m0_be = 4'($urandom);
      m0_addr = $urandom; m0_wdata = $urandom;
      m1_req = ($urandom_range(0, 9) < 6); m1_we = 1'($urandom); m1_be = 4'($urandom);
      m1_addr = $urandom; m1_wdata = $urandom;
      data_rvalid = ($urandom_range(0, 9) < 3); data_rdata = $urandom;
      #1;
      tmo_now = TMO_EN && owner >= 0 && !data_rvalid && age == TMO - 1;
      done    = owner >= 0 && (data_rvalid || tmo_now);
      rv0e    = owner == 0 && done && !killed;
      rv1e    = owner == 1 && done && !killed;
      rd_e    = tmo_now ? 32'h0 : data_rdata;
      checks++; if (data_req !== (owner >= 0) || busy !== (owner >= 0)) begin errors++; $display("FAIL rnd_c%0d_req got %b/%b exp %b", c, data_req, busy, (owner >= 0)); end
      checks++; if (tmo !== tmo_now) begin errors++; $display("FAIL rnd_c%0d_timeout got %b exp %b", c, tmo, tmo_now); end
      checks++; if ({data_we, data_be, data_addr, data_wdata} !== {q_we, q_be, q_addr, q_wdata})
        begin errors++; $display("FAIL rnd_c%0d_fields got %b %h %h %h exp %b %h %h %h", c, data_we, data_be, data_addr, data_wdata, q_we, q_be, q_addr, q_wdata); end
      checks++; if (m0_rvalid !== rv0e || m1_rvalid !== rv1e) begin errors++; $display("FAIL rnd_c%0d_rvalid got %b%b exp %b%b", c, m0_rvalid, m1_rvalid, rv0e, rv1e); end
      checks++; if (rv0e ? (m0_rdata !== rd_e) : (owner != 0 && m0_rdata !== 32'h0)) begin errors++; $display("FAIL rnd_c%0d_m0_rdata got %h exp %h", c, m0_rdata, rv0e ? rd_e : 32'h0); end
      checks++; if (rv1e ? (m1_rdata !== rd_e) : (owner != 1 && m1_rdata !== 32'h0)) begin errors++; $display("FAIL rnd_c%0d_m1_rdata got %h exp %h", c, m1_rdata, rv1e ? rd_e : 32'h0); end
      if (owner < 0) begin
        if (m0_req || m1_req) begin
          pick = (m0_req && m1_req) ? 1 - last : (m0_req ? 0 : 1);
          owner = pick; last = pick; killed = 1'b0; age = 0;
          if (pick == 0) begin q_we = m0_we; q_be = m0_be; q_addr = m0_addr; q_wdata = m0_wdata; end
          else           begin q_we = m1_we; q_be = m1_be; q_addr = m1_addr; q_wdata = m1_wdata; end
        end
      end else if (done) begin
        owner = -1; killed = 1'b0;
      end else begin
        if (!(owner == 0 ? m0_req : m1_req)) killed = 1'b1;
        age++;
      end
    end
    @(negedge clk);
    clear_inputs();
  endtask

  initial begin
    arstn = 1'b0;
    clear_inputs();
    test_reset();
    test_m0_load();
    test_tie();
    test_store_stable();
    test_kill();
    test_async_reset();
    test_timeout();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
